// File: rtl/m_uart_rx_pkg.sv
// Shared UART definitions: default bit period and receiver state encodings.
package m_uart_rx_pkg;

  // Clocks per bit period shared by the UART transmitter and receiver (1 Mbaud at 50 MHz).
  localparam int UART_WCNT = 50;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  // True when the sampled line goes from high to low.
  function automatic logic is_fall(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/m_uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous input pin; resets to 1 (idle-high lines).
module m_sync2 (
  input  logic w_clk,
  input  logic w_rst,
  input  logic w_d,
  output logic r_q
);

  logic meta_r;

  // Two-stage capture of the asynchronous pin, both stages preset to the idle level.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      meta_r <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      meta_r <= w_d;
      r_q    <= meta_r;
    end
  end

endmodule

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-entry valid/ready
// holding register and sticky frame-error / overrun flags.
module m_uart_rx
  import m_uart_rx_pkg::*;
#(
  parameter int WCNT = UART_WCNT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rx,
  input  logic       w_ready,
  input  logic       w_clr,
  output logic [7:0] r_data,
  output logic       r_valid,
  output logic       r_frame_err,
  output logic       r_overrun
);

  localparam int CW = $clog2(WCNT) + 1;
  // The counter restarts at 0 the cycle after each event, so the terminal
  // count is one less than the distance to the next sample point.
  localparam logic [CW-1:0] HALF_M1 = CW'(WCNT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(WCNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  rx_state_e   state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]  bit_r;
  logic [7:0]  shift_r;
  logic        prev_r;
  logic        rx_s;

  logic        fall_s;
  logic        half_hit_s;
  logic        full_hit_s;
  logic        hs_s;
  logic        stop_ok_s;
  logic        stop_bad_s;
  logic        load_s;
  logic        ovr_set_s;

  m_sync2 u_sync (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_d   (w_rx),
    .r_q   (rx_s)
  );

  // Previous synchronised sample, used for falling-edge detection.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= rx_s;
    end
  end

  // Sample-point decodes and delivery decisions for the current cycle.
  always_comb begin
    fall_s     = is_fall(prev_r, rx_s);
    half_hit_s = (cnt_r == HALF_M1);
    full_hit_s = (cnt_r == FULL_M1);
    hs_s       = r_valid & w_ready;
    stop_ok_s  = (state_r == RX_STOP) && full_hit_s && rx_s;
    stop_bad_s = (state_r == RX_STOP) && full_hit_s && !rx_s;
    // A full register that is being drained this cycle can take the new byte.
    load_s     = stop_ok_s && (!r_valid || w_ready);
    ovr_set_s  = stop_ok_s && r_valid && !w_ready;
  end

  // Receive FSM: bit timing, data shifting and framing.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_r <= RX_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
    end else begin
      case (state_r)
        RX_IDLE: begin
          cnt_r <= CNT_ZERO;
          bit_r <= 3'd0;
          if (fall_s) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (half_hit_s) begin
            cnt_r   <= CNT_ZERO;
            // A line back high at mid-start is a glitch, not a frame.
            state_r <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (full_hit_s) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {rx_s, shift_r[7:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (full_hit_s) begin
            cnt_r   <= CNT_ZERO;
            // Returning to IDLE at mid-stop lets a back-to-back start edge be seen.
            state_r <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_WAIT_HIGH: begin
          cnt_r <= CNT_ZERO;
          // Hold off through a break so it yields a single error.
          if (rx_s) begin
            state_r <= RX_IDLE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Holding register and sticky error flags; a set event beats a clear.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (load_s) begin
        r_data  <= shift_r;
        r_valid <= 1'b1;
      end else if (hs_s) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      if (stop_bad_s) begin
        r_frame_err <= 1'b1;
      end else if (w_clr) begin
        r_frame_err <= 1'b0;
      end else begin
        r_frame_err <= r_frame_err;
      end

      if (ovr_set_s) begin
        r_overrun <= 1'b1;
      end else if (w_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

endmodule

// File: tb/tb_m_uart_rx.sv
// Self-checking bench for m_uart_rx: table-driven frames, hand sequences for
// the corner cases, and randomized frames against a byte-level reference model.
module tb_m_uart_rx;

  localparam int W = 50;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       w_rx;
  logic       w_ready;
  logic       w_clr;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_frame_err;
  logic       r_overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_c0 = 0;
  int rise_cyc = -1;
  int valid_cnt = 0;
  int ferr_rises = 0;
  logic last_valid = 1'b0;
  logic last_ferr = 1'b0;
  logic [7:0] rcv_q[$];
  logic [7:0] exp_q[$];

  m_uart_rx #(.WCNT(W)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_rx        (w_rx),
    .w_ready     (w_ready),
    .w_clr       (w_clr),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .r_frame_err (r_frame_err),
    .r_overrun   (r_overrun)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) cyc <= cyc + 1;

  // Consumer-side monitor, sampled away from the active edge.
  always @(negedge w_clk) begin
    if (r_valid && w_ready) rcv_q.push_back(r_data);
    if (r_valid && !last_valid) rise_cyc = cyc;
    if (r_valid) valid_cnt = valid_cnt + 1;
    if (r_frame_err && !last_ferr) ferr_rises = ferr_rises + 1;
    last_valid = r_valid;
    last_ferr  = r_frame_err;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  task automatic pulse_clr();
    w_clr = 1'b1;
    wait_clk(1);
    w_clr = 1'b0;
  endtask

  // Drive one 8N1 frame; optionally raise w_ready only in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pulse_ready);
    w_rx = 1'b0;
    last_c0 = cyc;
    wait_clk(W);
    for (int i = 0; i < 8; i++) begin
      w_rx = d[i];
      wait_clk(W);
    end
    w_rx = stop;
    if (pulse_ready) begin
      wait_clk(27);
      w_ready = 1'b1;
      wait_clk(1);
      w_ready = 1'b0;
      wait_clk(W - 28);
    end else begin
      wait_clk(W);
    end
    w_rx = 1'b1;
  endtask

  task automatic reset_mon();
    rcv_q.delete();
    valid_cnt  = 0;
    ferr_rises = 0;
    rise_cyc   = -1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_rx;
    logic       exp_ferr;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic       exp_ferr;

    vt[0] = '{8'h61, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vt[2] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vt[3] = '{8'hC3, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h7E, 1'b1, 1'b1, 1'b0};
    vt[5] = '{8'hFF, 1'b0, 1'b0, 1'b1};

    w_rst = 1'b1; w_rx = 1'b1; w_ready = 1'b0; w_clr = 1'b0;
    wait_clk(3);
    chk("rst_data", {24'd0, r_data}, 32'h0);
    chk("rst_valid", {31'd0, r_valid}, 32'h0);
    chk("rst_ferr", {31'd0, r_frame_err}, 32'h0);
    chk("rst_ovr", {31'd0, r_overrun}, 32'h0);
    w_rst = 1'b0;
    wait_clk(5);

    // 1: basic byte with exact latency
    w_ready = 1'b1;
    reset_mon();
    send_frame(8'h61, 1'b1, 1'b0);
    wait_clk(5);
    chk("t1_count", rcv_q.size(), 32'd1);
    if (rcv_q.size() > 0) chk("t1_data", {24'd0, rcv_q[0]}, 32'h61);
    chk("t1_latency", rise_cyc, last_c0 + 478);
    chk("t1_valid_cycles", valid_cnt, 32'd1);
    chk("t1_ferr", {31'd0, r_frame_err}, 32'h0);
    chk("t1_ovr", {31'd0, r_overrun}, 32'h0);

    // 2: glitch then a real byte
    reset_mon();
    w_rx = 1'b0;
    wait_clk(10);
    w_rx = 1'b1;
    wait_clk(100);
    chk("t2_glitch_valid", valid_cnt, 32'd0);
    chk("t2_glitch_ferr", {31'd0, r_frame_err}, 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_clk(5);
    chk("t2_count", rcv_q.size(), 32'd1);
    if (rcv_q.size() > 0) chk("t2_data", {24'd0, rcv_q[0]}, 32'h3C);

    // 3: bad stop bit followed by a break
    reset_mon();
    send_frame(8'h55, 1'b0, 1'b0);
    w_rx = 1'b0;
    wait_clk(200);
    w_rx = 1'b1;
    wait_clk(60);
    chk("t3_ferr", {31'd0, r_frame_err}, 32'h1);
    chk("t3_ferr_once", ferr_rises, 32'd1);
    chk("t3_no_valid", valid_cnt, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_clk(5);
    chk("t3_count", rcv_q.size(), 32'd1);
    if (rcv_q.size() > 0) chk("t3_data", {24'd0, rcv_q[0]}, 32'hA5);
    pulse_clr();
    chk("t3_ferr_clr", {31'd0, r_frame_err}, 32'h0);

    // 4: overrun, drain, and reload in the stop-sample handshake cycle
    reset_mon();
    w_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    wait_clk(5);
    chk("t4_valid", {31'd0, r_valid}, 32'h1);
    chk("t4_hold", {24'd0, r_data}, 32'h12);
    chk("t4_ovr", {31'd0, r_overrun}, 32'h1);
    w_ready = 1'b1;
    wait_clk(1);
    w_ready = 1'b0;
    chk("t4_drained", {31'd0, r_valid}, 32'h0);
    chk("t4_got12", rcv_q.size(), 32'd1);
    pulse_clr();
    chk("t4_ovr_clr", {31'd0, r_overrun}, 32'h0);
    send_frame(8'h78, 1'b1, 1'b0);
    send_frame(8'h56, 1'b1, 1'b1);
    wait_clk(3);
    chk("t4_reload", {24'd0, r_data}, 32'h56);
    chk("t4_reload_valid", {31'd0, r_valid}, 32'h1);
    chk("t4_no_ovr", {31'd0, r_overrun}, 32'h0);
    chk("t4_got78", {24'd0, rcv_q[rcv_q.size()-1]}, 32'h78);
    w_ready = 1'b1;
    wait_clk(3);

    // 5: back-to-back frames
    reset_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clk(5);
    chk("t5_count", rcv_q.size(), 32'd2);
    if (rcv_q.size() == 2) begin
      chk("t5_first", {24'd0, rcv_q[0]}, 32'h00);
      chk("t5_second", {24'd0, rcv_q[1]}, 32'hFF);
    end
    chk("t5_ferr", {31'd0, r_frame_err}, 32'h0);
    chk("t5_ovr", {31'd0, r_overrun}, 32'h0);

    // 6: reset in the middle of bit 4
    w_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    wait_clk(3);
    chk("t6_pre_ovr", {31'd0, r_overrun}, 32'h1);
    d = 8'hAB;
    w_rx = 1'b0;
    wait_clk(W);
    for (int i = 0; i < 4; i++) begin
      w_rx = d[i];
      wait_clk(W);
    end
    w_rx = d[4];
    wait_clk(W / 2);
    #3 w_rst = 1'b1;
    #1;
    chk("t6_rst_data", {24'd0, r_data}, 32'h0);
    chk("t6_rst_valid", {31'd0, r_valid}, 32'h0);
    chk("t6_rst_ovr", {31'd0, r_overrun}, 32'h0);
    chk("t6_rst_ferr", {31'd0, r_frame_err}, 32'h0);
    w_rx = 1'b1;
    wait_clk(3);
    w_rst = 1'b0;
    w_ready = 1'b1;
    reset_mon();
    wait_clk(2 * W);
    chk("t6_aborted_silent", valid_cnt, 32'd0);
    send_frame(8'h61, 1'b1, 1'b0);
    wait_clk(5);
    chk("t6_count", rcv_q.size(), 32'd1);
    if (rcv_q.size() > 0) chk("t6_data", {24'd0, rcv_q[0]}, 32'h61);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      reset_mon();
      send_frame(vt[i].data, vt[i].stop, 1'b0);
      wait_clk(2 * W);
      chk("tab_count", rcv_q.size(), {31'd0, vt[i].exp_rx});
      if (vt[i].exp_rx && rcv_q.size() > 0) chk("tab_data", {24'd0, rcv_q[0]}, {24'd0, vt[i].data});
      chk("tab_ferr", {31'd0, r_frame_err}, {31'd0, vt[i].exp_ferr});
      pulse_clr();
    end

    // Randomized frames against the byte-level reference model
    reset_mon();
    exp_q.delete();
    exp_ferr = 1'b0;
    for (int k = 0; k < 25; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (stop) exp_q.push_back(d);
      else exp_ferr = 1'b1;
      send_frame(d, stop, 1'b0);
      if (gap > 0) wait_clk(gap * W);
    end
    wait_clk(2 * W);
    chk("rnd_count", rcv_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < rcv_q.size()) chk("rnd_data", {24'd0, rcv_q[k]}, {24'd0, exp_q[k]});
    end
    chk("rnd_ferr", {31'd0, r_frame_err}, {31'd0, exp_ferr});
    chk("rnd_ovr", {31'd0, r_overrun}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
